// File: rtl/fft_pkg.sv
// Shared constants for the 16-point radix-2 DIT FFT: widths, twiddle table
// and small helpers used by both the datapath and the butterfly.
package fft_pkg;

    localparam int N       = 16;
    localparam int DW      = 16;
    localparam int IW      = 24;
    localparam int TW      = 16;
    localparam int TW_FRAC = 14;

    // W16^i = cos - j*sin for i = 0..7, Q2.14 rounded to nearest
    localparam logic signed [TW-1:0] TW_COS [0:7] = '{
        16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
        16'sd0, -16'sd6270, -16'sd11585, -16'sd15137
    };
    localparam logic signed [TW-1:0] TW_SIN [0:7] = '{
        16'sd0, 16'sd6270, 16'sd11585, 16'sd15137,
        16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270
    };

    function automatic logic [3:0] bitrev4(input logic [3:0] i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

    function automatic logic [15:0] sat16(input logic signed [IW-1:0] v);
        if (v > 24'sd32767)
            return 16'h7FFF;
        else if (v < -24'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Complex radix-2 butterfly: y0 = a + b*W, y1 = a - b*W, with W = cos - j*sin.
module fft_butterfly
    import fft_pkg::*;
(
    input  logic signed [IW-1:0] a_re,
    input  logic signed [IW-1:0] a_im,
    input  logic signed [IW-1:0] b_re,
    input  logic signed [IW-1:0] b_im,
    input  logic signed [TW-1:0] w_cos,
    input  logic signed [TW-1:0] w_sin,
    output logic signed [IW-1:0] y0_re,
    output logic signed [IW-1:0] y0_im,
    output logic signed [IW-1:0] y1_re,
    output logic signed [IW-1:0] y1_im
);

    logic signed [IW+TW-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [IW-1:0]    t_re, t_im;

    assign p_rc = b_re * w_cos;
    assign p_is = b_im * w_sin;
    assign p_ic = b_im * w_cos;
    assign p_rs = b_re * w_sin;

    // Each product is truncated back to Q8.8 before the sums
    assign t_re = IW'((p_rc >>> TW_FRAC) + (p_is >>> TW_FRAC));
    assign t_im = IW'((p_ic >>> TW_FRAC) - (p_rs >>> TW_FRAC));

    assign y0_re = a_re + t_re;
    assign y0_im = a_im + t_im;
    assign y1_re = a_re - t_re;
    assign y1_im = a_im - t_im;

endmodule

// File: rtl/fft.sv
// 16-point streaming FFT: collects frames of real samples, runs a 4-stage
// registered DIT pipeline and emits bins serially in natural order.
module fft #(
    parameter int N  = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fir_data,
    input  logic          fir_valid,
    output logic [31:0]   fft_data,
    output logic          fft_valid,
    output logic [3:0]    freq,
    output logic          fft_fin
);
    import fft_pkg::*;

    logic [3:0]           cnt_reg;
    logic                 frame_reg;
    logic [4:0]           v_reg;
    logic signed [DW-1:0] samp_mem [0:15];

    logic signed [IW-1:0] st_re [0:4][0:15];
    logic signed [IW-1:0] st_im [0:4][0:15];
    logic signed [IW-1:0] bf_re [0:3][0:15];
    logic signed [IW-1:0] bf_im [0:3][0:15];

    logic [31:0]          bank_mem [0:15];
    logic [3:0]           out_cnt_reg;
    logic                 busy_reg;

    // Stage gs combines pairs H = 2^gs apart; twiddle step shrinks as H grows
    genvar gs, gi;
    generate
        for (gs = 0; gs < 4; gs++) begin : g_stage
            for (gi = 0; gi < 8; gi++) begin : g_bf
                localparam int H   = 1 << gs;
                localparam int TOP = (gi / H) * 2 * H + (gi % H);
                localparam int BOT = TOP + H;
                localparam int TWI = (gi % H) * (8 / H);
                fft_butterfly u_bf (
                    .a_re  (st_re[gs][TOP]),
                    .a_im  (st_im[gs][TOP]),
                    .b_re  (st_re[gs][BOT]),
                    .b_im  (st_im[gs][BOT]),
                    .w_cos (TW_COS[TWI]),
                    .w_sin (TW_SIN[TWI]),
                    .y0_re (bf_re[gs][TOP]),
                    .y0_im (bf_im[gs][TOP]),
                    .y1_re (bf_re[gs][BOT]),
                    .y1_im (bf_im[gs][BOT])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            frame_reg <= 1'b0;
            v_reg     <= '0;
        end else begin
            frame_reg <= fir_valid && (cnt_reg == 4'(N - 1));
            if (fir_valid)
                cnt_reg <= cnt_reg + 4'd1;
            v_reg <= {v_reg[3:0], frame_reg};
        end
    end

    // Datapath moves every cycle; v_reg tags which stage holds a real frame
    always_ff @(posedge clk) begin
        if (fir_valid)
            samp_mem[cnt_reg] <= fir_data;
        for (int i = 0; i < 16; i++) begin
            st_re[0][i] <= IW'(samp_mem[bitrev4(4'(i))]);
            st_im[0][i] <= '0;
        end
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) begin
                st_re[s+1][i] <= bf_re[s][i];
                st_im[s+1][i] <= bf_im[s][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fft_data    <= '0;
            fft_valid   <= 1'b0;
            freq        <= '0;
            fft_fin     <= 1'b0;
            out_cnt_reg <= '0;
            busy_reg    <= 1'b0;
        end else if (v_reg[4] && !busy_reg) begin
            for (int i = 0; i < 16; i++)
                bank_mem[i] <= {sat16(st_re[4][i]), sat16(st_im[4][i])};
            fft_data    <= {sat16(st_re[4][0]), sat16(st_im[4][0])};
            fft_valid   <= 1'b1;
            freq        <= 4'd0;
            fft_fin     <= 1'b0;
            out_cnt_reg <= 4'd1;
            busy_reg    <= 1'b1;
        end else if (busy_reg) begin
            fft_data    <= bank_mem[out_cnt_reg];
            fft_valid   <= 1'b1;
            freq        <= out_cnt_reg;
            fft_fin     <= (out_cnt_reg == 4'd15);
            out_cnt_reg <= out_cnt_reg + 4'd1;
            if (out_cnt_reg == 4'd15)
                busy_reg <= 1'b0;
        end else begin
            fft_data  <= '0;
            fft_valid <= 1'b0;
            freq      <= '0;
            fft_fin   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft.sv
// Bench for the 16-point FFT: floating-point DFT reference with a scoreboard
// checked every cycle, plus literal expectations for the directed frames.
module tb_fft;

    logic        clk = 1'b0;
    logic        rst;
    logic        fir_valid;
    logic [15:0] fir_data;
    logic [31:0] fft_data;
    logic        fft_valid;
    logic [3:0]  freq;
    logic        fft_fin;

    always #5 clk = ~clk;

    fft dut (
        .clk       (clk),
        .rst       (rst),
        .fir_data  (fir_data),
        .fir_valid (fir_valid),
        .fft_data  (fft_data),
        .fft_valid (fft_valid),
        .freq      (freq),
        .fft_fin   (fft_fin)
    );

    typedef struct {
        int     re;
        int     im;
        int     k;
        longint cyc;
    } exp_t;

    localparam int TOL = 8;
    localparam real PI = 3.14159265358979;

    exp_t   exp_q[$];
    exp_t   cur;
    int     frame_x[$];
    int     m_re[16], m_im[16];
    int     got_re[16], got_im[16];
    int     checks = 0, errors = 0;
    int     fin_cnt = 0, valid_cnt = 0, run = 0, max_run = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Direct DFT in real arithmetic, rounded and saturated to Q8.8
    task automatic model_dft(input int x[16]);
        for (int k = 0; k < 16; k++) begin
            real sr, si, ang;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 16; n++) begin
                ang = 2.0 * PI * n * k / 16.0;
                sr  = sr + x[n] * $cos(ang);
                si  = si - x[n] * $sin(ang);
            end
            m_re[k] = sat(int'(sr));
            m_im[k] = sat(int'(si));
        end
    endtask

    task automatic put(input logic v, input int d);
        int arr[16];
        @(negedge clk);
        fir_valid = v;
        fir_data  = d[15:0];
        @(posedge clk);
        #1;
        if (v && !rst) begin
            frame_x.push_back(d);
            if (frame_x.size() == 16) begin
                for (int n = 0; n < 16; n++) arr[n] = frame_x[n];
                model_dft(arr);
                for (int k = 0; k < 16; k++) begin
                    exp_t e;
                    e.re  = m_re[k];
                    e.im  = m_im[k];
                    e.k   = k;
                    e.cyc = cyc + 6 + k;
                    exp_q.push_back(e);
                end
                frame_x.delete();
            end
        end
    endtask

    task automatic lit(input string name, input int got, input int want, input int tol);
        checks++;
        if (iabs(got - want) > tol) begin
            errors++;
            $display("FAIL %s got %0d want %0d (tol %0d)", name, got, want, tol);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        fir_valid = 1'b0;
        while ((exp_q.size() != 0 || fft_valid) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d bins want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard: every cycle either an expected bin or quiet, zeroed outputs
    always @(negedge clk) begin
        if (fft_valid === 1'b1) begin
            valid_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (fft_fin) fin_cnt++;
            got_re[freq] = $signed(fft_data[31:16]);
            got_im[freq] = $signed(fft_data[15:0]);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bin cyc %0d freq %0d data %h want none", cyc, freq, fft_data);
            end else begin
                cur = exp_q.pop_front();
                if (cyc != cur.cyc || int'(freq) != cur.k || fft_fin != (cur.k == 15) ||
                    iabs($signed(fft_data[31:16]) - cur.re) > TOL ||
                    iabs($signed(fft_data[15:0]) - cur.im) > TOL) begin
                    errors++;
                    $display("FAIL bin cyc %0d freq %0d fin %0d re %0d im %0d want cyc %0d k %0d re %0d im %0d",
                             cyc, freq, fft_fin, $signed(fft_data[31:16]), $signed(fft_data[15:0]),
                             cur.cyc, cur.k, cur.re, cur.im);
                end
            end
        end else if (fft_valid === 1'b0) begin
            run = 0;
            checks++;
            if (fft_data != 32'd0 || freq != 4'd0 || fft_fin != 1'b0) begin
                errors++;
                $display("FAIL idle_outputs cyc %0d data %h freq %0d fin %0d want 0", cyc, fft_data, freq, fft_fin);
            end
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_bin cyc %0d k %0d want at cyc %0d", cyc, exp_q[0].k, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    int fin0, val0, v;

    initial begin
        rst       = 1'b1;
        fir_valid = 1'b0;
        fir_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_valid", int'(fft_valid), 0, 0);
        lit("reset_data", int'(fft_data), 0, 0);
        lit("reset_fin", int'(fft_fin), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // DC
        for (int n = 0; n < 16; n++) put(1'b1, 256);
        lit("model_dc_bin0", m_re[0], 4096, 0);
        lit("model_dc_bin3", m_re[3], 0, 0);
        drain();
        lit("dc_bin0_re", got_re[0], 4096, 1);
        lit("dc_bin0_im", got_im[0], 0, 1);
        lit("dc_bin7_re", got_re[7], 0, 1);
        $display("frame dc bin0 re %0d", got_re[0]);

        // Impulse with gaps mid-frame
        put(1'b1, 256);
        put(1'b0, 0);
        for (int n = 1; n < 16; n++) begin
            put(1'b1, 0);
            if (n == 6) begin put(1'b0, 0); put(1'b0, 0); end
        end
        drain();
        for (int k = 0; k < 16; k++) begin
            lit("impulse_re", got_re[k], 256, 0);
            lit("impulse_im", got_im[k], 0, 0);
        end
        $display("frame impulse bin9 re %0d im %0d", got_re[9], got_im[9]);

        // Alternating
        for (int n = 0; n < 16; n++) put(1'b1, (n % 2 == 0) ? 256 : -256);
        drain();
        lit("alt_bin8_re", got_re[8], 4096, 1);
        lit("alt_bin0_re", got_re[0], 0, 1);
        lit("alt_bin4_re", got_re[4], 0, 1);
        $display("frame alternating bin8 re %0d", got_re[8]);

        // Cosine at bin 1
        for (int n = 0; n < 16; n++) put(1'b1, int'(256.0 * $cos(2.0 * PI * n / 16.0)));
        lit("model_cos_bin1", m_re[1], 2048, 2);
        drain();
        lit("cos_bin1_re", got_re[1], 2048, 4);
        lit("cos_bin15_re", got_re[15], 2048, 4);
        lit("cos_bin1_im", got_im[1], 0, 4);
        lit("cos_bin4_re", got_re[4], 0, 4);
        $display("frame cosine bin1 re %0d bin15 re %0d", got_re[1], got_re[15]);

        // Saturation
        for (int n = 0; n < 16; n++) put(1'b1, 32767);
        drain();
        lit("sat_bin0_re", got_re[0], 32767, 0);
        lit("sat_bin1_re", got_re[1], 0, 1);
        $display("frame saturation bin0 re %0d", got_re[0]);

        // Reset mid-frame: the 7 partial samples must vanish
        fin0 = fin_cnt;
        for (int n = 0; n < 7; n++) put(1'b1, 1000);
        @(negedge clk);
        rst       = 1'b1;
        fir_valid = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        fir_valid = 1'b0;
        frame_x.delete();
        for (int n = 0; n < 16; n++) put(1'b1, n * 16 - 100);
        drain();
        lit("reset_frames", fin_cnt - fin0, 1, 0);
        lit("reset_bin0_re", got_re[0], 16 * 120 - 1600, 2);
        $display("frame after reset bin0 re %0d", got_re[0]);

        // 1024 continuous samples
        fin0    = fin_cnt;
        val0    = valid_cnt;
        max_run = 0;
        for (int n = 0; n < 1024; n++) begin
            v = int'($urandom_range(0, 1536)) - 768;
            put(1'b1, v);
        end
        drain();
        lit("stream_fin_pulses", fin_cnt - fin0, 64, 0);
        lit("stream_valid_cycles", valid_cnt - val0, 1024, 0);
        lit("stream_longest_run", max_run, 1024, 0);
        $display("stream fin %0d valid %0d run %0d", fin_cnt - fin0, valid_cnt - val0, max_run);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
